// File: rtl/heap_sort_ctrl.sv
// Batch sorter in front of an external max-heap: pushes an input batch, then pops it
// back out largest-first. Every heap operation is paced by a fixed settle window.
module heap_sort_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned SETTLE = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_last_o,
  output logic             heap_push_o,
  output logic             heap_pop_o,
  output logic [WIDTH-1:0] heap_data_in_o,
  input  logic [WIDTH-1:0] heap_data_out_i,
  input  logic             heap_full_i
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {
    S_FILL,
    S_POP,
    S_WAIT,
    S_OUT
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic             drain_q, drain_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             heap_push_q, heap_push_d;
  logic             heap_pop_q, heap_pop_d;
  logic [WIDTH-1:0] heap_data_in_q, heap_data_in_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_FILL;
      count_q        <= '0;
      settle_q       <= '0;
      drain_q        <= 1'b0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_last_q     <= 1'b0;
      heap_push_q    <= 1'b0;
      heap_pop_q     <= 1'b0;
      heap_data_in_q <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      settle_q       <= settle_d;
      drain_q        <= drain_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_last_q     <= out_last_d;
      heap_push_q    <= heap_push_d;
      heap_pop_q     <= heap_pop_d;
      heap_data_in_q <= heap_data_in_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    settle_d       = (settle_q == '0) ? '0 : settle_q - SW'(1);
    drain_d        = drain_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_last_d     = out_last_q;
    heap_push_d    = 1'b0;
    heap_pop_d     = 1'b0;
    heap_data_in_d = heap_data_in_q;
    in_ready_d     = 1'b0;

    case (state_q)
      S_FILL: begin
        if (in_valid_i && in_ready_q) begin
          heap_push_d    = 1'b1;
          heap_data_in_d = in_data_i;
          count_d        = count_q + CW'(1);
          settle_d       = SW'(SETTLE);
          if (in_last_i || (count_q + CW'(1)) == CW'(DEPTH)) begin
            drain_d = 1'b1;
          end
        end else if (drain_q && settle_q == '0) begin
          state_d = S_POP;
        end
      end
      S_POP: begin
        if (count_q != '0) begin
          heap_pop_d = 1'b1;
          settle_d   = SW'(SETTLE);
          count_d    = count_q - CW'(1);
          state_d    = S_WAIT;
        end else begin
          drain_d = 1'b0;
          state_d = S_FILL;
        end
      end
      S_WAIT: begin
        if (settle_q == '0) begin
          out_data_d  = heap_data_out_i;
          out_last_d  = (count_q == '0);
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_valid_q && out_ready_i) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (count_q != '0) begin
            state_d = S_POP;
          end else begin
            drain_d = 1'b0;
            state_d = S_FILL;
          end
        end
      end
      default: state_d = S_FILL;
    endcase

    // Ready is registered, so it is derived from the upcoming state; a pending drain blocks intake
    in_ready_d = (state_d == S_FILL) && (settle_d == '0) && (count_d < CW'(DEPTH))
                 && !drain_d && !heap_full_i;
  end

  assign in_ready_o     = in_ready_q;
  assign out_valid_o    = out_valid_q;
  assign out_data_o     = out_data_q;
  assign out_last_o     = out_last_q;
  assign heap_push_o    = heap_push_q;
  assign heap_pop_o     = heap_pop_q;
  assign heap_data_in_o = heap_data_in_q;

endmodule

// File: doc/heap_sort_ctrl.md
Name: heap_sort_ctrl

Overview:
Batch-sort controller that sits directly in front of the 8-entry max-heap and drives its push/pop port. It accepts a valid/ready byte stream, pushes each byte into the heap, then pops the heap dry and emits the bytes in descending order on a valid/ready output stream. The heap has no busy/ready output, so this block paces every heap operation with a fixed settle window and keeps its own occupancy count.

Parameters:
WIDTH, 8, data width; must equal the heap's data width.
DEPTH, 8, heap capacity; the batch size is capped at DEPTH.
SETTLE, 5, idle cycles after each heap push/pop pulse; must be at least the worst-case heapify cycles plus 1.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset; the heap shares this same rst_n
in_valid  in  1  upstream data valid
in_ready  out  1  block can accept in_data this cycle
in_data  in  WIDTH  upstream byte
in_last  in  1  marks the final byte of a batch; sampled with in_data
out_valid  out  1  sorted byte available
out_ready  in  1  downstream accepts
out_data  out  WIDTH  sorted byte, largest first
out_last  out  1  marks the final (smallest) byte of the batch
heap_push  out  1  one-cycle push pulse to the heap
heap_pop  out  1  one-cycle pop pulse to the heap
heap_data_in  out  WIDTH  byte presented with heap_push
heap_data_out  in  WIDTH  heap root as registered by the heap on a pop
heap_full  in  1  heap full flag; used only as a push guard

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - state=FILL, count=0, settle counter=0.
  - in_ready=0, out_valid=0, out_last=0, out_data=0.
  - heap_push=0, heap_pop=0, heap_data_in=0.
- count has width clog2(DEPTH+1) and tracks heap occupancy. It never exceeds DEPTH and never underflows. heap_empty is not used.
- Settle counter:
  - Loaded with SETTLE on every push or pop pulse, then decrements to 0.
  - No heap pulse and no in_ready while it is nonzero.
  - Effect: consecutive heap operations are at least SETTLE+1 cycles apart.
- FILL state:
  - in_ready = (settle==0) && (count<DEPTH) && !heap_full.
  - On a handshake (in_valid && in_ready), in the next cycle: heap_push=1 and heap_data_in=in_data for exactly one cycle, count+1, settle loaded.
  - If the accepted byte had in_last=1, or count reaches DEPTH, set a drain flag.
  - When the drain flag is set and settle==0, go to POP.
- POP state (count>0):
  - Drive heap_pop=1 for one cycle, load settle, decrement count, go to WAIT.
- WAIT state:
  - When settle==0: out_data<=heap_data_out, out_last<=(count==0), out_valid<=1, go to OUT.
- OUT state:
  - Hold out_valid, out_data and out_last stable until out_valid && out_ready.
  - On that transfer: out_valid<=0, out_last<=0.
  - Then go to POP if count>0; otherwise clear the drain flag and go to FILL.
- in_ready is 0 in POP, WAIT and OUT. A new batch cannot start until the current batch is fully drained.
- heap_push and heap_pop are never high in the same cycle.
- Boundary cases:
  - in_last on the DEPTH-th byte: a single drain is triggered.
  - A batch of one byte is output with out_last=1.
  - Duplicate values are all emitted.
  - in_valid while draining is ignored (no handshake).
  - rst_n low mid-batch: immediate return to FILL with count=0. The heap clears on the same reset, so there are no stale entries.

Test Plan:
- Push 3, 7, 5 (in_last on 5), out_ready=1 -> out_data 7, 5, 3; out_last=1 only with 3; in_ready returns high afterwards.
- Push 8 bytes 10, 40, 20, 80, 30, 70, 60, 50 with no in_last -> auto drain after the 8th byte; in_ready=0 during drain; output 80, 70, 60, 50, 40, 30, 20, 10 with out_last on 10.
- Hold in_valid=1 continuously -> in_ready pulses exactly SETTLE+1=6 cycles apart; heap_push is one cycle wide and follows each handshake by one cycle.
- Batch 9, 9, 2 (last on 2), out_ready=0 for 10 cycles after the first out_valid -> out_data holds at 9 throughout the stall; the sequence then completes as 9, 9, 2.
- Assert rst_n=0 after the second output of an 8-byte drain -> all outputs at reset values; the next batch 1, 4 (last) outputs 4, 1 with no stale data.
- Single-byte batch 0xFF with in_last -> one output 0xFF with out_last=1; heap_pop pulses exactly once.
